// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared widths, types and helpers for the write-back stage
// Purpose: single home for data/register-file sizing and the queued write record.
// Exports: DATA_W, RF_ADDR_W, RF_REG, RF_ZERO, reg_addr_t, reg_data_t, wb_entry_t,
//          writes_reg() (true when a destination actually updates the register file).
package wb_stage_pkg;
    localparam int DATA_W    = 16;
    localparam int RF_ADDR_W = 3;
    localparam int RF_REG    = 8;
    localparam logic [RF_ADDR_W-1:0] RF_ZERO = '0;

    typedef logic [RF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]    reg_data_t;

    typedef struct packed {
        reg_addr_t rd;
        reg_data_t data;
    } wb_entry_t;

    function automatic logic writes_reg(input reg_addr_t rd);
        return rd != RF_ZERO;
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - 2-entry in-order queue of pending load write-backs
// Purpose: buffers accepted load results until the write port is free.
// Ports: clk, rst (sync, active-high); push + push_entry enqueue; pop dequeues head;
//        head is the oldest entry; full/empty reflect registered occupancy.
module wb_fifo
    import wb_stage_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);
    wb_entry_t  mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Push and pop together leave occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage: ALU/load arbitration, load scoreboard, forwarding
// Purpose: merges never-stalled ALU results with handshaked load results onto one
//          registered register-file write port, tracks loads in flight and flags hazards.
// Ports: clock, rst (sync, active-high); alu_valid/alu_rd/alu_data ALU result;
//        ld_valid/ld_rd/ld_data/ld_ready load result handshake; ld_issue/ld_issue_rd
//        load issued by decode; rs1/rs2/rd decode fields; hazard stall request;
//        rf_we/rf_w_addr/rf_w_data write port; fwd1/fwd2 bypass selects for rs1/rs2.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [RF_ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 ld_valid,
    input  logic [RF_ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0]    ld_data,
    output logic                 ld_ready,
    input  logic                 ld_issue,
    input  logic [RF_ADDR_W-1:0] ld_issue_rd,
    input  logic [RF_ADDR_W-1:0] rs1,
    input  logic [RF_ADDR_W-1:0] rs2,
    input  logic [RF_ADDR_W-1:0] rd,
    output logic                 hazard,
    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_w_addr,
    output logic [DATA_W-1:0]    rf_w_data,
    output logic                 fwd1,
    output logic                 fwd2
);
    logic              fifo_full;
    logic              fifo_empty;
    wb_entry_t         fifo_head;
    wb_entry_t         ld_entry;
    logic              push;
    logic              pop;
    logic              alu_wr;
    logic [RF_REG-1:0] pending;
    logic [RF_REG-1:0] pend_set;
    logic [RF_REG-1:0] pend_clr;

    // Ready deliberately ignores a same-cycle pop so it is a pure register decode.
    assign ld_ready = !fifo_full && !rst;
    assign push     = ld_valid && ld_ready;
    assign alu_wr   = alu_valid && writes_reg(alu_rd);
    // A zero-destination ALU result does not occupy the port, so the load may go.
    assign pop      = !fifo_empty && !alu_wr && !rst;

    assign ld_entry.rd   = ld_rd;
    assign ld_entry.data = ld_data;

    wb_fifo u_fifo (
        .clk        (clock),
        .rst        (rst),
        .push       (push),
        .push_entry (ld_entry),
        .pop        (pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (ld_issue && writes_reg(ld_issue_rd)) begin
            pend_set[ld_issue_rd] = 1'b1;
        end
        if (pop) begin
            pend_clr[fifo_head.rd] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            pending <= '0;
        end else begin
            // Set applied after clear so a re-issue in the pop cycle stays pending.
            pending <= (pending & ~pend_clr) | pend_set;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            rf_we     <= 1'b0;
            rf_w_addr <= '0;
            rf_w_data <= '0;
        end else if (alu_wr) begin
            rf_we     <= 1'b1;
            rf_w_addr <= alu_rd;
            rf_w_data <= alu_data;
        end else if (pop && writes_reg(fifo_head.rd)) begin
            rf_we     <= 1'b1;
            rf_w_addr <= fifo_head.rd;
            rf_w_data <= fifo_head.data;
        end else begin
            // Address/data hold so consumers never see a spurious change.
            rf_we     <= 1'b0;
        end
    end

    assign hazard = pending[rs1] | pending[rs2] | pending[rd];
    assign fwd1   = rf_we && (rf_w_addr == rs1);
    assign fwd2   = rf_we && (rf_w_addr == rs2);
endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage with write scoreboard
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic                 clock = 1'b0;
    logic                 rst;
    logic                 alu_valid;
    logic [RF_ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0]    alu_data;
    logic                 ld_valid;
    logic [RF_ADDR_W-1:0] ld_rd;
    logic [DATA_W-1:0]    ld_data;
    logic                 ld_ready;
    logic                 ld_issue;
    logic [RF_ADDR_W-1:0] ld_issue_rd;
    logic [RF_ADDR_W-1:0] rs1;
    logic [RF_ADDR_W-1:0] rs2;
    logic [RF_ADDR_W-1:0] rd;
    logic                 hazard;
    logic                 rf_we;
    logic [RF_ADDR_W-1:0] rf_w_addr;
    logic [DATA_W-1:0]    rf_w_data;
    logic                 fwd1;
    logic                 fwd2;

    always #5 clock = ~clock;

    wb_stage dut (
        .clock       (clock),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .hazard      (hazard),
        .rf_we       (rf_we),
        .rf_w_addr   (rf_w_addr),
        .rf_w_data   (rf_w_data),
        .fwd1        (fwd1),
        .fwd2        (fwd2)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    wb_entry_t   alu_q[$];
    wb_entry_t   ld_q[$];
    logic        alu_prev = 1'b0;
    logic [RF_REG-1:0] tb_pend = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst         = 1'b0;
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        ld_valid    = 1'b0;
        ld_rd       = '0;
        ld_data     = '0;
        ld_issue    = 1'b0;
        ld_issue_rd = '0;
        rs1         = '0;
        rs2         = '0;
        rd          = '0;
    endtask

    // Called after driving a cycle's inputs: checks the write that appeared this cycle.
    task automatic settle();
        wb_entry_t e;
        #2;
        if (alu_prev) begin
            chk("sb_alu_we", 32'(rf_we), 1);
            if (alu_q.size() != 0) begin
                e = alu_q.pop_front();
                chk("sb_alu_addr", 32'(rf_w_addr), 32'(e.rd));
                chk("sb_alu_data", 32'(rf_w_data), 32'(e.data));
            end
        end else if (rf_we === 1'b1) begin
            if (ld_q.size() == 0) begin
                chk("sb_spurious_we", 32'(rf_we), 0);
            end else begin
                e = ld_q.pop_front();
                tb_pend[e.rd] = 1'b0;
                chk("sb_ld_addr", 32'(rf_w_addr), 32'(e.rd));
                chk("sb_ld_data", 32'(rf_w_data), 32'(e.data));
            end
        end
    endtask

    // Records what this cycle's inputs should produce, then moves to the next cycle.
    task automatic adv();
        logic      alu_next;
        wb_entry_t e;
        alu_next = alu_valid && (alu_rd != RF_ZERO) && !rst;
        if (alu_next) begin
            e.rd = alu_rd;
            e.data = alu_data;
            alu_q.push_back(e);
        end
        if (ld_valid && ld_ready && (ld_rd != RF_ZERO) && !rst) begin
            e.rd = ld_rd;
            e.data = ld_data;
            ld_q.push_back(e);
        end
        if (ld_issue && (ld_issue_rd != RF_ZERO) && !rst) begin
            if (tb_pend[ld_issue_rd])
                $display("note: illegal ld_issue to already-pending rd %0d at %0t", ld_issue_rd, $time);
            tb_pend[ld_issue_rd] = 1'b1;
        end
        if (rst) begin
            ld_q.delete();
            alu_q.delete();
            tb_pend = '0;
        end
        @(posedge clock);
        #1;
        alu_prev = alu_next;
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clock);
        #1;

        // Reset behaviour
        rst = 1'b1; settle(); chk("rst_ld_ready_0", 32'(ld_ready), 0); adv();
        rst = 1'b1; settle();
        chk("rst_we", 32'(rf_we), 0);
        chk("rst_addr", 32'(rf_w_addr), 0);
        chk("rst_data", 32'(rf_w_data), 0);
        chk("rst_hazard", 32'(hazard), 0);
        chk("rst_ld_ready_1", 32'(ld_ready), 0);
        adv();
        settle(); chk("post_rst_ready", 32'(ld_ready), 1); adv();

        // ALU write registered one cycle later, forwarding, hold on idle
        alu_valid = 1'b1; alu_rd = 3'd3; alu_data = 16'h1234; settle(); adv();
        rs1 = 3'd3; settle();
        chk("alu_we", 32'(rf_we), 1);
        chk("alu_fwd1", 32'(fwd1), 1);
        chk("alu_fwd2", 32'(fwd2), 0);
        adv();
        rs1 = 3'd3; settle();
        chk("hold_we", 32'(rf_we), 0);
        chk("hold_fwd1", 32'(fwd1), 0);
        chk("hold_addr", 32'(rf_w_addr), 3);
        chk("hold_data", 32'(rf_w_data), 32'h1234);
        adv();

        // ALU write to register zero is dropped
        alu_valid = 1'b1; alu_rd = 3'd0; alu_data = 16'hFFFF; settle(); adv();
        settle();
        chk("zero_alu_we", 32'(rf_we), 0);
        chk("zero_alu_addr", 32'(rf_w_addr), 3);
        chk("zero_alu_data", 32'(rf_w_data), 32'h1234);
        adv();

        // Load issue/scoreboard hazard timeline
        ld_issue = 1'b1; ld_issue_rd = 3'd2; rs2 = 3'd2; settle();
        chk("ld_hz_c1", 32'(hazard), 0); adv();
        rs2 = 3'd2; settle(); chk("ld_hz_c2", 32'(hazard), 1); adv();
        rs2 = 3'd2; settle(); chk("ld_hz_c3", 32'(hazard), 1); adv();
        rs2 = 3'd2; ld_valid = 1'b1; ld_rd = 3'd2; ld_data = 16'hBEEF; settle();
        chk("ld_ready_c4", 32'(ld_ready), 1);
        chk("ld_hz_c4", 32'(hazard), 1);
        adv();
        rs2 = 3'd2; settle();
        chk("ld_hz_c5", 32'(hazard), 1);
        chk("ld_we_c5", 32'(rf_we), 0);
        adv();
        rs2 = 3'd2; settle();
        chk("ld_we_c6", 32'(rf_we), 1);
        chk("ld_hz_c6", 32'(hazard), 0);
        chk("ld_fwd2_c6", 32'(fwd2), 1);
        adv();

        // Load to register zero: accepted, popped, never written
        ld_valid = 1'b1; ld_rd = 3'd0; ld_data = 16'hDEAD; settle();
        chk("zero_ld_ready", 32'(ld_ready), 1); adv();
        settle(); adv();
        settle();
        chk("zero_ld_we", 32'(rf_we), 0);
        chk("zero_ld_data_hold", 32'(rf_w_data), 32'hBEEF);
        adv();

        // Back-to-back loads under continuous ALU traffic
        alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 16'hA000;
        ld_valid = 1'b1; ld_rd = 3'd5; ld_data = 16'h1111; settle();
        chk("bp_ready_0", 32'(ld_ready), 1); adv();
        alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 16'hA001;
        ld_valid = 1'b1; ld_rd = 3'd6; ld_data = 16'h2222; settle();
        chk("bp_ready_1", 32'(ld_ready), 1); adv();
        for (int i = 2; i < 4; i++) begin
            alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 16'hA000 + 16'(i);
            ld_valid = 1'b1; ld_rd = 3'd7; ld_data = 16'h3333; settle();
            chk("bp_ready_full", 32'(ld_ready), 0); adv();
        end
        ld_valid = 1'b1; ld_rd = 3'd7; ld_data = 16'h3333; settle();
        chk("bp_ready_pop_cycle", 32'(ld_ready), 0); adv();
        alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 16'hA005;
        ld_valid = 1'b1; ld_rd = 3'd7; ld_data = 16'h3333; settle();
        chk("bp_ready_after_idle", 32'(ld_ready), 1); adv();
        for (int i = 0; i < 5; i++) begin
            settle(); adv();
        end
        chk("bp_ld_drained", 32'(ld_q.size()), 0);
        chk("bp_alu_drained", 32'(alu_q.size()), 0);

        // Reset mid-operation discards queued loads and pending bits
        ld_issue = 1'b1; ld_issue_rd = 3'd5; settle(); adv();
        ld_issue = 1'b1; ld_issue_rd = 3'd6; settle(); adv();
        alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 16'hB000;
        ld_valid = 1'b1; ld_rd = 3'd5; ld_data = 16'h5555; settle();
        chk("mr_ready_0", 32'(ld_ready), 1); adv();
        alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 16'hB001;
        ld_valid = 1'b1; ld_rd = 3'd6; ld_data = 16'h6666; settle();
        chk("mr_ready_1", 32'(ld_ready), 1); adv();
        rst = 1'b1; settle();
        chk("mr_ready_in_rst", 32'(ld_ready), 0); adv();
        rs1 = 3'd5; rs2 = 3'd6; rd = 3'd5; settle();
        chk("mr_we", 32'(rf_we), 0);
        chk("mr_addr", 32'(rf_w_addr), 0);
        chk("mr_data", 32'(rf_w_data), 0);
        chk("mr_hazard", 32'(hazard), 0);
        chk("mr_ready_after", 32'(ld_ready), 1);
        adv();
        for (int i = 0; i < 4; i++) begin
            rs1 = 3'd5; rs2 = 3'd6; settle();
            chk("mr_no_we", 32'(rf_we), 0);
            adv();
        end

        // Re-issue to rd 4 in the cycle its queued load pops: set wins
        ld_issue = 1'b1; ld_issue_rd = 3'd4; settle(); adv();
        ld_valid = 1'b1; ld_rd = 3'd4; ld_data = 16'h4444; settle();
        chk("si_ready", 32'(ld_ready), 1); adv();
        ld_issue = 1'b1; ld_issue_rd = 3'd4; settle(); adv();
        rs1 = 3'd4; settle();
        chk("si_we", 32'(rf_we), 1);
        chk("si_hazard", 32'(hazard), 1);
        chk("si_fwd1", 32'(fwd1), 1);
        adv();
        rs1 = 3'd4; settle(); chk("si_hazard_hold", 32'(hazard), 1); adv();
        ld_valid = 1'b1; ld_rd = 3'd4; ld_data = 16'h5555; settle(); adv();
        rs1 = 3'd4; settle(); adv();
        rs1 = 3'd4; settle();
        chk("si_clean_hazard", 32'(hazard), 0);
        chk("si_clean_we", 32'(rf_we), 1);
        adv();

        settle();
        chk("end_ld_q", 32'(ld_q.size()), 0);
        chk("end_alu_q", 32'(alu_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL take DATA_W=16, RF_ADDR_W=3, RF_REG=8 and RF_ZERO=0 from the shared definitions: data width, register-address width, register count, zero-register index.
REQ-002 SHALL run on one clock; reset is synchronous and active-high.
REQ-003 Port: clock  in  1  single clock, all state updates on rising edge.
REQ-004 Port: rst  in  1  synchronous active-high reset.
REQ-005 Ports: alu_valid  in  1; alu_rd  in  RF_ADDR_W; alu_data  in  DATA_W: ALU result, one per cycle, never stalled.
REQ-006 Ports: ld_valid  in  1; ld_rd  in  RF_ADDR_W; ld_data  in  DATA_W; ld_ready  out  1: load-result valid/ready handshake.
REQ-007 Ports: ld_issue  in  1; ld_issue_rd  in  RF_ADDR_W: decode marks a load issued to rd.
REQ-008 Ports: rs1, rs2, rd  in  RF_ADDR_W: register fields of the instruction in decode.
REQ-009 Port: hazard  out  1: decode must stall.
REQ-010 Ports: rf_we  out  1; rf_w_addr  out  RF_ADDR_W; rf_w_data  out  DATA_W: register-file write port.
REQ-011 Ports: fwd1, fwd2  out  1: rs1/rs2 match the in-flight write; decode takes rf_w_data.

Function
REQ-012 ALU path SHALL register its write: alu_valid with alu_rd!=RF_ZERO in cycle N gives rf_we=1 in cycle N+1.
REQ-013 A load beat SHALL be accepted only when ld_valid && ld_ready; upstream holds ld_valid, ld_rd and ld_data stable until accepted.
REQ-014 Accepted loads SHALL enter a 2-entry in-order FIFO; ld_ready = FIFO not full, regardless of a same-cycle pop.
REQ-015 FIFO head SHALL pop only in a cycle without a writing ALU result (ALU priority); load accepted in N, no ALU traffic: rf_we=1 in N+2.
REQ-016 Simultaneous push and pop SHALL both take effect; occupancy unchanged.
REQ-017 Writes with rd==RF_ZERO (ALU or load) SHALL yield rf_we=0; a load to RF_ZERO is still accepted and popped.
REQ-018 Scoreboard: 8 pending bits; ld_issue with ld_issue_rd!=RF_ZERO sets pending[ld_issue_rd]; popping a load clears pending[its rd] on the pop edge.
REQ-019 Set and clear of the same bit in one cycle: set wins.
REQ-020 hazard = pending[rs1] | pending[rs2] | pending[rd], combinational; pending[RF_ZERO] is always 0.
REQ-021 fwd1 = rf_we && rf_w_addr==rs1; fwd2 likewise, combinational.
REQ-022 When rf_we=0, rf_w_addr and rf_w_data SHALL hold their last values.
REQ-023 ld_issue to an already-pending rd is illegal; the bench SHALL flag it.

Reset
REQ-024 rst in a cycle SHALL, at that edge: empty the FIFO, clear all pending bits, set rf_we=0, rf_w_addr=0, rf_w_data=0.
REQ-025 While rst=1, ld_ready SHALL be 0 and all inputs ignored; ld_ready=1 in the first cycle after rst deasserts.
REQ-026 rst mid-operation SHALL discard queued loads without writing them.

Structure
REQ-027 DATA_W, RF_ADDR_W, RF_REG and RF_ZERO SHALL live in the shared definitions file only; no local copies.
REQ-028 The FIFO SHALL be the sub-module wb_fifo: 2 entries, payload {rd, data}, push/pop/full/empty.
REQ-029 Scoreboard, arbitration, output register and forwarding SHALL sit in wb_stage.

Verification
REQ-030 alu_valid, rd=3, data=0x1234 in cycle 5 -> rf_we=1, addr=3, data=0x1234 in cycle 6; fwd1=1 when rs1=3 in cycle 6.
REQ-031 ld_issue rd=2 in cycle 1; load rd=2, data=0xBEEF accepted in cycle 4, ALU idle -> hazard=1 for rs2=2 in cycles 2..5, rf_we in cycle 6, hazard=0 in cycle 6.
REQ-032 Three load beats back-to-back while alu_valid stays high -> ld_ready=0 after two accepted; third accepted after the first ALU-idle cycle; writes in acceptance order.
REQ-033 alu_valid with rd=0, data=0xFFFF -> rf_we stays 0; register 0 never written.
REQ-034 Two loads queued, rst pulsed one cycle -> no rf_we afterwards, pending all 0, ld_ready=1 the cycle after rst.
REQ-035 ld_issue rd=4 in the same cycle a queued load to rd=4 pops -> pending[4]=1 afterwards; bench flags it per REQ-023.
